// File: rtl/usb_pkg.sv
// Shared USB line-state constants and the downstream port FSM state type.
package usb_pkg;

  localparam logic [1:0] SE0  = 2'b00;
  localparam logic [1:0] SE1  = 2'b11;
  localparam logic [1:0] FS_J = 2'b10;
  localparam logic [1:0] FS_K = 2'b01;

  typedef enum logic [2:0] {
    ST_DISCONNECTED = 3'd0,
    ST_ATTACH_WAIT  = 3'd1,
    ST_CONNECTED    = 3'd2,
    ST_DETACH_WAIT  = 3'd3,
    ST_RESET_DRIVE  = 3'd4,
    ST_RECOVER      = 3'd5
  } port_state_e;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Only the two differential idle states identify an attached full/low-speed device.
  function automatic logic is_idle_line(input logic [1:0] line);
    return (line == FS_J) || (line == FS_K);
  endfunction

endpackage

// File: rtl/usb_line_debounce.sv
// Holds a candidate line value and counts consecutive matching samples; reused for
// attach (J or K candidate) and detach (SE0 candidate).
module usb_line_debounce
  import usb_pkg::*;
#(
  parameter int unsigned STABLE_N = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic       i_track,
  input  logic       i_clear,
  input  logic [1:0] i_line,
  output logic       o_match,
  output logic       o_reach
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       r_cand;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cand  <= SE0;
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_cand  <= i_line;
      r_count <= CNT_W'(1);
    end else if (i_track && o_match && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_match = (i_line == r_cand);
  // True when the current sample is the STABLE_N-th consecutive match.
  assign o_reach = o_match && ((32'(r_count) + 32'd1) >= STABLE_N);

endmodule

// File: rtl/usb_downstream_reset_driver.sv
// Downstream port line controller: debounced attach/detach, J/K polarity latch, and
// bus-reset signalling (SE0 then J recovery). All outputs are registered from state.
module usb_downstream_reset_driver
  import usb_pkg::*;
#(
  parameter int unsigned RESET_TIME    = 20,
  parameter int unsigned RECOVERY_TIME = 4,
  parameter int unsigned DEBOUNCE_TIME = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] usb_signals,
  input  logic       port_reset_req,
  output logic [1:0] usb_out,
  output logic       usb_oe,
  output logic       port_reset_busy,
  output logic       port_reset_done,
  output logic       connected,
  output logic [1:0] j_state,
  output logic [1:0] k_state
);

  localparam int unsigned    DRV_W   = $clog2(umax(RESET_TIME, RECOVERY_TIME) + 1);
  localparam logic [DRV_W-1:0] DRV_MAX = '1;

  port_state_e      r_state;
  port_state_e      w_next;
  logic [DRV_W-1:0] r_drv_cnt;
  logic [1:0]       r_j_lat;
  logic             r_just_rec;
  logic             w_drv_last;
  logic             w_db_load;
  logic             w_db_track;
  logic             w_db_clear;
  logic             w_db_match;
  logic             w_db_reach;
  logic [1:0]       w_out_nx;
  logic             w_oe_nx;
  logic             w_done_nx;
  logic             w_conn_nx;
  logic [1:0]       w_k_nx;

  usb_line_debounce #(
    .STABLE_N (DEBOUNCE_TIME)
  ) u_debounce (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_db_load),
    .i_track (w_db_track),
    .i_clear (w_db_clear),
    .i_line  (usb_signals),
    .o_match (w_db_match),
    .o_reach (w_db_reach)
  );

  assign w_drv_last = ((r_state == ST_RESET_DRIVE) && (32'(r_drv_cnt) == RESET_TIME - 1)) ||
                      ((r_state == ST_RECOVER)     && (32'(r_drv_cnt) == RECOVERY_TIME - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_DISCONNECTED;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_db_load  = 1'b0;
    w_db_track = 1'b0;
    w_db_clear = 1'b0;
    case (r_state)
      ST_DISCONNECTED: begin
        if (is_idle_line(usb_signals)) begin
          w_db_load = 1'b1;
          w_next    = (DEBOUNCE_TIME == 1) ? ST_CONNECTED : ST_ATTACH_WAIT;
        end
      end
      ST_ATTACH_WAIT: begin
        if (w_db_match && w_db_reach) begin
          w_db_clear = 1'b1;
          w_next     = ST_CONNECTED;
        end else if (w_db_match) begin
          w_db_track = 1'b1;
        end else begin
          w_db_clear = 1'b1;
          w_next     = ST_DISCONNECTED;
        end
      end
      ST_CONNECTED: begin
        // A reset request wins over a simultaneous SE0 sample.
        if (port_reset_req) begin
          w_next = ST_RESET_DRIVE;
        end else if (usb_signals == SE0) begin
          w_db_load = 1'b1;
          w_next    = (DEBOUNCE_TIME == 1) ? ST_DISCONNECTED : ST_DETACH_WAIT;
        end
      end
      ST_DETACH_WAIT: begin
        if (w_db_match && w_db_reach) begin
          w_db_clear = 1'b1;
          w_next     = ST_DISCONNECTED;
        end else if (w_db_match) begin
          w_db_track = 1'b1;
        end else begin
          w_db_clear = 1'b1;
          w_next     = ST_CONNECTED;
        end
      end
      ST_RESET_DRIVE: if (w_drv_last) w_next = ST_RECOVER;
      ST_RECOVER:     if (w_drv_last) w_next = ST_CONNECTED;
      default:        w_next = ST_DISCONNECTED;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_drv_cnt  <= '0;
      r_j_lat    <= SE0;
      r_just_rec <= 1'b0;
    end else begin
      if (w_next != r_state)         r_drv_cnt <= '0;
      else if (r_drv_cnt != DRV_MAX) r_drv_cnt <= r_drv_cnt + 1'b1;
      // On attach the accepted sample equals the candidate, so latch the line directly.
      if ((w_next == ST_CONNECTED) &&
          ((r_state == ST_ATTACH_WAIT) || (r_state == ST_DISCONNECTED)))
        r_j_lat <= usb_signals;
      else if (w_next == ST_DISCONNECTED)
        r_j_lat <= SE0;
      r_just_rec <= (r_state == ST_RECOVER) && (w_next == ST_CONNECTED);
    end
  end

  always_comb begin
    w_oe_nx   = (r_state == ST_RESET_DRIVE) || (r_state == ST_RECOVER);
    w_out_nx  = (r_state == ST_RECOVER) ? r_j_lat : SE0;
    w_done_nx = (r_state == ST_CONNECTED) && r_just_rec;
    w_conn_nx = r_state inside {ST_CONNECTED, ST_DETACH_WAIT, ST_RESET_DRIVE, ST_RECOVER};
    w_k_nx    = w_conn_nx ? ~r_j_lat : SE0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      usb_out         <= SE0;
      usb_oe          <= 1'b0;
      port_reset_busy <= 1'b0;
      port_reset_done <= 1'b0;
      connected       <= 1'b0;
      j_state         <= SE0;
      k_state         <= SE0;
    end else begin
      usb_out         <= w_out_nx;
      usb_oe          <= w_oe_nx;
      port_reset_busy <= w_oe_nx;
      port_reset_done <= w_done_nx;
      connected       <= w_conn_nx;
      j_state         <= r_j_lat;
      k_state         <= w_k_nx;
    end
  end

endmodule
